// File: rtl/irq_pkg.sv
// Shared definitions for the machine-mode interrupt controller: register
// offsets, mcause values and the request FSM encoding.
package irq_pkg;

  // Word offsets within the block (mmio_addr[4:2]).
  typedef enum logic [2:0] {
    REG_MSIP        = 3'd0,
    REG_EXT_PEND    = 3'd1,
    REG_EXT_EN      = 3'd2,
    REG_CLAIM       = 3'd3,
    REG_MTIME_LO    = 3'd4,
    REG_MTIME_HI    = 3'd5,
    REG_MTIMECMP_LO = 3'd6,
    REG_MTIMECMP_HI = 3'd7
  } reg_e;

  // mcause values (interrupt bit set) for the three sources.
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Request handshake with the exception unit.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line followed by a
// rising-edge detector. rise_o pulses for one clk, two cycles after the pin.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the value from
      // before this edge, so the chain really is three stages deep.
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt source: 64-bit mtime/mtimecmp timer, software
// interrupt bit, NUM_EXT edge-triggered external lines with claim register,
// and a request/ack/mret handshake toward the exception unit.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_EXT   = 4,
  parameter int TIMER_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mmio_we,
  input  logic               mmio_re,
  input  logic [4:0]         mmio_addr,
  input  logic [31:0]        mmio_wdata,
  output logic [31:0]        mmio_rdata,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               mie_global,
  output logic               irq_req,
  output logic [31:0]        irq_cause,
  input  logic               irq_ack,
  input  logic               mret
);

  localparam int              PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TIMER_DIV - 1);

  // State registers
  logic [PW-1:0]      presc_q,    presc_d;
  logic [63:0]        mtime_q,    mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic               msip_q,     msip_d;
  logic [NUM_EXT-1:0] ext_pend_q, ext_pend_d;
  logic [NUM_EXT-1:0] ext_en_q,   ext_en_d;
  logic [31:0]        rdata_q,    rdata_d;
  logic [31:0]        cause_q,    cause_d;
  state_e             state_q,    state_d;

  // Decode and derived signals
  reg_e               reg_sel;
  logic               unused_addr_bits;
  logic [NUM_EXT-1:0] ext_rise;
  logic [NUM_EXT-1:0] ext_active;
  logic [NUM_EXT-1:0] claim_onehot;
  logic [31:0]        claim_id;
  logic               do_claim;
  logic               tick;
  logic               mtip;
  logic               meip;

  assign reg_sel          = reg_e'(mmio_addr[4:2]);
  assign unused_addr_bits = ^mmio_addr[1:0];

  // One synchroniser/edge detector per external line.
  for (genvar i = 0; i < NUM_EXT; i++) begin : g_ext
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .async_i(ext_irq[i]),
      .rise_o (ext_rise[i])
    );
  end

  assign ext_active   = ext_pend_q & ext_en_q;
  assign claim_onehot = ext_active & (~ext_active + 1'b1);  // lowest set bit
  assign do_claim     = mmio_re && (reg_sel == REG_CLAIM);
  assign meip         = |ext_active;
  assign mtip         = (mtime_q >= mtimecmp_q);

  // Claim ID: index of the lowest enabled pending line plus one, 0 if none.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    claim_id = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (claim_onehot[i]) claim_id = 32'(i + 1);
    end
  end

  // Timer: prescaler wrap advances mtime; bus writes to a half override it.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = mtime_q + 64'(tick);
    if (mmio_we && reg_sel == REG_MTIME_LO) mtime_d = {mtime_q[63:32], mmio_wdata};
    if (mmio_we && reg_sel == REG_MTIME_HI) mtime_d = {mmio_wdata, mtime_q[31:0] + 32'(tick)};
    mtimecmp_d = mtimecmp_q;
    if (mmio_we && reg_sel == REG_MTIMECMP_LO) mtimecmp_d[31:0]  = mmio_wdata;
    if (mmio_we && reg_sel == REG_MTIMECMP_HI) mtimecmp_d[63:32] = mmio_wdata;
  end

  // Software bit, enables and pending bits; a new edge beats a claim-clear.
  always_comb begin
    msip_d     = msip_q;
    ext_en_d   = ext_en_q;
    if (mmio_we && reg_sel == REG_MSIP)   msip_d   = mmio_wdata[0];
    if (mmio_we && reg_sel == REG_EXT_EN) ext_en_d = mmio_wdata[NUM_EXT-1:0];
    ext_pend_d = (ext_pend_q & ~(do_claim ? claim_onehot : '0)) | ext_rise;
  end

  // Read mux, registered so data appears the cycle after mmio_re.
  always_comb begin
    rdata_d = rdata_q;
    if (mmio_re) begin
      unique case (reg_sel)
        REG_MSIP:        rdata_d = {31'b0, msip_q};
        REG_EXT_PEND:    rdata_d = 32'(ext_pend_q);
        REG_EXT_EN:      rdata_d = 32'(ext_en_q);
        REG_CLAIM:       rdata_d = claim_id;
        REG_MTIME_LO:    rdata_d = mtime_q[31:0];
        REG_MTIME_HI:    rdata_d = mtime_q[63:32];
        REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        default:         rdata_d = '0;
      endcase
    end
  end

  // Request FSM: latch highest-priority cause on entry to REQ, hold until ack.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mie_global && (meip || msip_q || mtip)) begin
          state_d = ST_REQ;
          cause_d = meip ? CAUSE_MEI : (msip_q ? CAUSE_MSI : CAUSE_MTI);
        end
      end
      ST_REQ:     if (irq_ack) state_d = ST_SERVICE;
      ST_SERVICE: if (mret)    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // All architectural state, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RESET;
      msip_q     <= 1'b0;
      ext_pend_q <= '0;
      ext_en_q   <= '0;
      rdata_q    <= '0;
      cause_q    <= '0;
      state_q    <= ST_IDLE;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ext_pend_q <= ext_pend_d;
      ext_en_q   <= ext_en_d;
      rdata_q    <= rdata_d;
      cause_q    <= cause_d;
      state_q    <= state_d;
    end
  end

  assign mmio_rdata = rdata_q;
  assign irq_req    = (state_q == ST_REQ);
  assign irq_cause  = cause_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (NUM_EXT=4, TIMER_DIV=1). Inputs change
// and outputs are sampled on the falling edge.
module tb_irq_controller;

  localparam logic [2:0] A_MSIP = 3'd0, A_PEND = 3'd1, A_EN = 3'd2, A_CLAIM = 3'd3;
  localparam logic [2:0] A_MTL  = 3'd4, A_MCL  = 3'd6, A_MCH = 3'd7;
  localparam logic [31:0] MEI = 32'h8000_000B, MSI = 32'h8000_0003, MTI = 32'h8000_0007;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_we, mmio_re;
  logic [4:0]  mmio_addr;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic [3:0]  ext_irq;
  logic        mie_global, irq_req, irq_ack, mret;
  logic [31:0] irq_cause;
  logic [31:0] d;

  int tests = 0;
  int fails = 0;

  irq_controller #(.NUM_EXT(4), .TIMER_DIV(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mmio_we   (mmio_we),
    .mmio_re   (mmio_re),
    .mmio_addr (mmio_addr),
    .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata),
    .ext_irq   (ext_irq),
    .mie_global(mie_global),
    .irq_req   (irq_req),
    .irq_cause (irq_cause),
    .irq_ack   (irq_ack),
    .mret      (mret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    mmio_addr  = {a, 2'b00};
    mmio_wdata = v;
    mmio_we    = 1'b1;
    @(negedge clk);
    mmio_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    mmio_addr = {a, 2'b00};
    mmio_re   = 1'b1;
    @(negedge clk);
    mmio_re   = 1'b0;
    v         = mmio_rdata;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mmio_we = 1'b0; mmio_re = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    ext_irq = '0; mie_global = 1'b1; irq_ack = 1'b0; mret = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_req", irq_req, 0);
    check("reset_cause", irq_cause, 0);
    check("reset_rdata", mmio_rdata, 0);

    // Idle 100 cycles: mtime counts, mtimecmp all-ones so no timer request.
    repeat (100) @(negedge clk);
    check("idle_no_req", irq_req, 0);
    bus_read(A_MTL, d);
    check("mtime_after_100", (d >= 99 && d <= 101), 1);

    // Timer: mtime=10, mtimecmp=20; mtime reaches 20 after 8 more edges.
    bus_write(A_MTL, 32'd10);
    bus_write(A_MCH, 32'd0);
    bus_write(A_MCL, 32'd20);
    check("timer_not_yet", irq_req, 0);
    repeat (8) @(negedge clk);
    check("timer_at_20_no_req_yet", irq_req, 0);
    @(negedge clk);
    check("timer_req", irq_req, 1);
    check("timer_cause", irq_cause, MTI);
    pulse_ack();
    check("timer_ack_drops_req", irq_req, 0);
    bus_write(A_MCL, 32'hFFFF_FFFF);
    bus_write(A_MCH, 32'hFFFF_FFFF);
    pulse_mret();
    repeat (3) @(negedge clk);
    check("timer_cleared", irq_req, 0);

    // External: enable lines 1,2; edge on line 2 takes 3 clk to pend bit.
    bus_write(A_EN, 32'h6);
    ext_irq[2] = 1'b1;
    repeat (3) @(negedge clk);
    check("ext_latency_no_req", irq_req, 0);
    @(negedge clk);
    check("ext_req", irq_req, 1);
    check("ext_cause", irq_cause, MEI);
    ext_irq = 4'b0011;
    repeat (4) @(negedge clk);
    ext_irq = '0;
    bus_read(A_PEND, d);
    check("ext_pend_all", d, 32'h7);
    bus_read(A_CLAIM, d);
    check("claim_first", d, 2);
    bus_read(A_CLAIM, d);
    check("claim_second", d, 3);
    bus_read(A_CLAIM, d);
    check("claim_none", d, 0);
    bus_read(A_PEND, d);
    check("ext_pend_disabled_left", d, 32'h1);
    pulse_ack();
    pulse_mret();
    repeat (2) @(negedge clk);
    check("ext_no_source_idle", irq_req, 0);

    // msip and mtip together with MIE off, then on: MSI wins.
    mie_global = 1'b0;
    bus_write(A_MCH, 32'd0);
    bus_write(A_MCL, 32'd0);
    bus_write(A_MSIP, 32'd1);
    repeat (2) @(negedge clk);
    check("mie_gates_request", irq_req, 0);
    mie_global = 1'b1;
    @(negedge clk);
    check("msi_req", irq_req, 1);
    check("msi_cause", irq_cause, MSI);
    pulse_ack();
    check("msi_ack", irq_req, 0);
    pulse_mret();
    check("idle_reentered_no_req", irq_req, 0);
    @(negedge clk);
    check("rereq_next_cycle", irq_req, 1);
    check("rereq_cause", irq_cause, MSI);

    // In REQ: withdraw source and MIE; request and cause hold.
    mie_global = 1'b0;
    bus_write(A_MSIP, 32'd0);
    repeat (2) @(negedge clk);
    check("req_held", irq_req, 1);
    check("cause_held", irq_cause, MSI);
    irq_ack = 1'b1;
    mret    = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    mret    = 1'b0;
    check("ack_with_mret", irq_req, 0);
    mie_global = 1'b1;
    repeat (3) @(negedge clk);
    check("mret_ignored_with_ack", irq_req, 0);
    pulse_ack();
    repeat (2) @(negedge clk);
    check("second_ack_ignored", irq_req, 0);
    pulse_mret();
    check("mret_to_idle", irq_req, 0);
    @(negedge clk);
    check("mti_after_mret", irq_req, 1);
    check("mti_cause", irq_cause, MTI);

    // Reset while in SERVICE with a pending external bit.
    pulse_ack();
    ext_irq[1] = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", irq_req, 0);
    check("async_rst_cause", irq_cause, 0);
    ext_irq = '0;
    @(negedge clk);
    rst = 1'b0;
    mie_global = 1'b0;
    bus_read(A_PEND, d);
    check("rst_pend_clear", d, 0);
    bus_read(A_MCL, d);
    check("rst_mtimecmp_lo", d, 32'hFFFF_FFFF);
    bus_read(A_MCH, d);
    check("rst_mtimecmp_hi", d, 32'hFFFF_FFFF);
    bus_read(A_EN, d);
    check("rst_ext_en", d, 0);

    // Write and read of MSIP in the same cycle returns the old value.
    mmio_addr  = {A_MSIP, 2'b00};
    mmio_wdata = 32'hFFFF_FFFF;
    mmio_we    = 1'b1;
    mmio_re    = 1'b1;
    @(negedge clk);
    mmio_we = 1'b0;
    mmio_re = 1'b0;
    check("we_re_old_value", mmio_rdata, 0);
    bus_read(A_MSIP, d);
    check("msip_bit0_only", d, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
